// File: rtl/spi_memory_controller_pkg.sv
// Shared constants, state encoding and frame builder for the SPI memory master.
package spi_mem_pkg;

  localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
  localparam logic [7:0] SPI_CMD_READ   = 8'h03;
  localparam int         SPI_FRAME_BITS = 40;
  localparam int         SPI_ADDR_BITS  = 24;
  // Bit-counter values of the last bit in the CMD and ADDR fields
  localparam int         SPI_CMD_LAST   = 7;
  localparam int         SPI_ADDR_LAST  = 31;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } spi_state_e;

  // Reads carry a zero data byte so the frame is always 40 bits long
  function automatic logic [SPI_FRAME_BITS-1:0] build_frame(
    input logic                     we,
    input logic [SPI_ADDR_BITS-1:0] addr,
    input logic [7:0]               wdata
  );
    return we ? {SPI_CMD_WRITE, addr, wdata} : {SPI_CMD_READ, addr, 8'h00};
  endfunction

endpackage

// File: rtl/spi_memory_controller_if.sv
// Bus-side request/response bundle of the SPI memory master.
interface spi_memory_controller_if;
  import spi_mem_pkg::*;

  logic                     req;
  logic                     we;
  logic [SPI_ADDR_BITS-1:0] addr;
  logic [7:0]               wdata;
  logic                     busy;
  logic                     done;
  logic [7:0]               rdata;

  // CPU side issues requests
  modport master (output req, we, addr, wdata, input busy, done, rdata);
  // Controller side serves them
  modport slave  (input req, we, addr, wdata, output busy, done, rdata);

endinterface

// File: rtl/spi_memory_controller_sclk_divider.sv
// SPI clock strobe generator: rise/fall pulses every CLK_HALF cycles while enabled.
module spi_sclk_divider #(
  parameter int CLK_HALF = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_sclk,
  output logic o_rise,
  output logic o_fall
);

  logic [7:0] r_phase;
  logic       w_wrap;

  assign w_wrap = (r_phase == 8'(CLK_HALF - 1));
  // Current SPI clock level decides which edge the wrap produces
  assign o_rise = i_en && w_wrap && !i_sclk;
  assign o_fall = i_en && w_wrap &&  i_sclk;

  // Phase counter restarts whenever the link is idle so bit 0 gets a full low phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_phase <= '0;
    else if (!i_en || w_wrap) r_phase <= '0;
    else                     r_phase <= r_phase + 8'd1;
  end

endmodule

// File: rtl/spi_memory_controller.sv
// Single-byte mode-0 SPI memory master: CMD(8) + ADDR(24) + DATA(8) per request.
module spi_memory_controller
  import spi_mem_pkg::*;
#(
  parameter int CLK_HALF = 1,
  parameter int CE_IDLE  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_memory_controller_if.slave bus,
  output logic                   spi_clk,
  output logic                   spi_mosi,
  output logic                   spi_ce,
  input  logic                   spi_miso
);

  spi_state_e                r_state, w_next;
  logic [SPI_FRAME_BITS-1:0] r_frame, w_frame_in;
  logic [5:0]                r_bitcnt;
  logic [6:0]                r_rx;
  logic [7:0]                r_rdata;
  logic                      r_we, r_busy, r_done;
  logic [15:0]               r_gap;
  logic                      w_active, w_rise, w_fall, w_last, w_gap_end, w_accept;

  assign w_active   = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_last     = (r_bitcnt == 6'(SPI_FRAME_BITS - 1));
  assign w_gap_end  = (r_state == ST_GAP) && (r_gap == 16'(CE_IDLE - 1));
  // The last gap cycle doubles as an accept slot so back-to-back requests keep CE high exactly CE_IDLE cycles
  assign w_accept   = bus.req && ((r_state == ST_IDLE) || w_gap_end);
  assign w_frame_in = build_frame(bus.we, bus.addr, bus.wdata);

  // MOSI is the frame MSB straight from the shift register flop
  assign spi_mosi   = r_frame[SPI_FRAME_BITS-1];
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.rdata  = r_rdata;

  spi_sclk_divider #(.CLK_HALF(CLK_HALF)) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_active),
    .i_sclk (spi_clk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state: field boundaries advance on the falling edge of their last bit
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.req) w_next = ST_CMD;
      ST_CMD:  if (w_fall && r_bitcnt == 6'(SPI_CMD_LAST))  w_next = ST_ADDR;
      ST_ADDR: if (w_fall && r_bitcnt == 6'(SPI_ADDR_LAST)) w_next = ST_DATA;
      ST_DATA: if (w_fall && w_last) w_next = ST_GAP;
      ST_GAP:  if (w_gap_end) w_next = bus.req ? ST_CMD : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Shift/sample datapath and link pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame  <= '0;
      r_bitcnt <= '0;
      r_rx     <= '0;
      r_rdata  <= '0;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_gap    <= '0;
      spi_clk  <= 1'b0;
      spi_ce   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_frame  <= w_frame_in;
        r_we     <= bus.we;
        r_bitcnt <= '0;
        r_busy   <= 1'b1;
        spi_ce   <= 1'b0;
        spi_clk  <= 1'b0;
      end else if (w_active) begin
        if (w_rise) spi_clk <= 1'b1;
        if (w_fall) begin
          spi_clk <= 1'b0;
          if (r_state == ST_DATA && !r_we) r_rx <= {r_rx[5:0], spi_miso};
          if (w_last) begin
            spi_ce  <= 1'b1;
            r_done  <= 1'b1;
            r_frame <= '0;
            r_gap   <= '0;
            if (!r_we) r_rdata <= {r_rx, spi_miso};
          end else begin
            r_frame  <= {r_frame[SPI_FRAME_BITS-2:0], 1'b0};
            r_bitcnt <= r_bitcnt + 6'd1;
          end
        end
      end else if (r_state == ST_GAP) begin
        if (w_gap_end) r_busy <= 1'b0;
        else           r_gap  <= r_gap + 16'd1;
      end
    end
  end

endmodule
